// File: rtl/fetch_pkg.sv
// Shared fetch-path types and constants for the instruction-fetch queue.
// The reset PC is shared with the PC register that feeds fetch_queue.
package fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;
    localparam int          FQ_AW    = 32;
    localparam int          FQ_DW    = 32;

    typedef struct packed {
        logic [FQ_AW-1:0] pc;
        logic [FQ_DW-1:0] instr;
        logic             filled;
    } fq_entry_t;

    function automatic int fq_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch-queue entry storage: per-entry {pc, instr, filled}, one allocate, one fill, one read port.
// Latency: writes visible the cycle after the edge; read port is combinational.
// Backpressure: none; the owner guarantees allocate and fill never target the same live entry.
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int PW    = fq_ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_alloc_vld,
    input  logic [PW-1:0] i_alloc_idx,
    input  logic [AW-1:0] i_alloc_pc,
    input  logic          i_fill_vld,
    input  logic [PW-1:0] i_fill_idx,
    input  logic [DW-1:0] i_fill_dat,
    input  logic [PW-1:0] i_rd_idx,
    output logic [AW-1:0] o_rd_pc,
    output logic [DW-1:0] o_rd_dat,
    output logic          o_rd_filled
);

    logic [AW-1:0]    r_pc    [DEPTH];
    logic [DW-1:0]    r_instr [DEPTH];
    logic [DEPTH-1:0] r_filled;

    // Only the filled bits need reset; pc/instr are qualified by them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filled <= '0;
        end else if (i_clr) begin
            r_filled <= '0;
        end else begin
            if (i_alloc_vld) r_filled[i_alloc_idx] <= 1'b0;
            if (i_fill_vld)  r_filled[i_fill_idx]  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_alloc_vld) r_pc[i_alloc_idx]   <= i_alloc_pc;
        if (i_fill_vld)  r_instr[i_fill_idx] <= i_fill_dat;
    end

    assign o_rd_pc     = r_pc[i_rd_idx];
    assign o_rd_dat    = r_instr[i_rd_idx];
    assign o_rd_filled = r_filled[i_rd_idx];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues pc_i to imem, queues in-order responses with their PC for decode.
// Latency: response to id_valid_o 1 cycle; 0 cycles when FETCH_QUEUE_BYPASS_EN is defined.
// Backpressure: id_ready_i low holds entries; requests stop once allocated + dropping reaches DEPTH.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int ADDRESS_WIDTH = 32,
    parameter  int DATA_WIDTH    = 32,
    parameter  int DEPTH         = 4,
    localparam int CW            = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] pc_i,
    output logic                     trigger_o,
    input  logic                     flush_i,
    output logic                     imem_req_valid_o,
    input  logic                     imem_req_ready_i,
    output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
    input  logic                     imem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]    imem_resp_data_i,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    output logic [DATA_WIDTH-1:0]    id_instr_o,
    output logic [ADDRESS_WIDTH-1:0] id_pc_o,
    output logic [CW-1:0]            count_o
);

    localparam int          PW      = fq_ptr_w(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [PW-1:0] r_wr_ptr, r_fill_ptr, r_rd_ptr;
    logic [CW-1:0] r_count, r_drop_cnt, r_inflight;

    logic [CW:0]              w_occ;
    logic                     w_req_vld, w_trig, w_resp_drop, w_resp_keep;
    logic                     w_pop, w_fill_vld, w_id_vld;
    logic                     w_rd_filled;
    logic [ADDRESS_WIDTH-1:0] w_rd_pc;
    logic [DATA_WIDTH-1:0]    w_rd_instr, w_id_instr;

    // Fetches still owed to a flushed path occupy request slots until they return.
    assign w_occ       = {1'b0, r_count} + {1'b0, r_drop_cnt};
    assign w_req_vld   = rst_n && !flush_i && (w_occ < DEPTH_C);
    assign w_trig      = w_req_vld && imem_req_ready_i;
    assign w_resp_drop = imem_resp_valid_i && (r_drop_cnt != '0);
    assign w_resp_keep = imem_resp_valid_i && (r_drop_cnt == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic w_bypass;
    assign w_bypass   = rst_n && w_resp_keep && !w_rd_filled && (r_inflight != '0)
                        && (r_fill_ptr == r_rd_ptr);
    assign w_id_vld   = (rst_n && w_rd_filled && (r_count != '0)) || w_bypass;
    assign w_id_instr = w_rd_filled ? w_rd_instr : imem_resp_data_i;
    assign w_fill_vld = w_resp_keep && !flush_i && !(w_bypass && id_ready_i);
`else
    assign w_id_vld   = rst_n && w_rd_filled && (r_count != '0);
    assign w_id_instr = w_rd_instr;
    assign w_fill_vld = w_resp_keep && !flush_i;
`endif

    assign w_pop = w_id_vld && id_ready_i && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else if (flush_i) begin
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop_cnt <= r_inflight + r_drop_cnt - CW'(imem_resp_valid_i);
        end else begin
            r_wr_ptr   <= r_wr_ptr + PW'(w_trig);
            r_fill_ptr <= r_fill_ptr + PW'(w_resp_keep);
            r_rd_ptr   <= r_rd_ptr + PW'(w_pop);
            r_count    <= r_count + CW'(w_trig) - CW'(w_pop);
            r_inflight <= r_inflight + CW'(w_trig) - CW'(w_resp_keep);
            r_drop_cnt <= r_drop_cnt - CW'(w_resp_drop);
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (ADDRESS_WIDTH),
        .DW    (DATA_WIDTH),
        .PW    (PW)
    ) u_mem (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (flush_i),
        .i_alloc_vld (w_trig),
        .i_alloc_idx (r_wr_ptr),
        .i_alloc_pc  (pc_i),
        .i_fill_vld  (w_fill_vld),
        .i_fill_idx  (r_fill_ptr),
        .i_fill_dat  (imem_resp_data_i),
        .i_rd_idx    (r_rd_ptr),
        .o_rd_pc     (w_rd_pc),
        .o_rd_dat    (w_rd_instr),
        .o_rd_filled (w_rd_filled)
    );

    assign trigger_o        = w_trig;
    assign imem_req_valid_o = w_req_vld;
    assign imem_addr_o      = pc_i;
    assign id_valid_o       = w_id_vld;
    assign id_instr_o       = w_id_instr;
    assign id_pc_o          = w_rd_pc;
    assign count_o          = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: PC register model, fixed-latency imem model, per-cycle vector table
// plus hand-written flush and reset sequences.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam logic [31:0] FLUSH_PC = 32'hBFC00100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0, req_rdy = 1'b0, id_rdy = 1'b0;
    logic        trigger, req_vld, resp_vld, id_valid;
    logic [31:0] tb_pc, imem_addr, resp_data, id_instr, id_pc;
    logic [2:0]  count;
    logic [1:0]  mem_lat = 2'd1;
    logic [2:0]  s_vld;
    logic [31:0] s_addr [3];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    fetch_queue #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_i              (tb_pc),
        .trigger_o         (trigger),
        .flush_i           (flush),
        .imem_req_valid_o  (req_vld),
        .imem_req_ready_i  (req_rdy),
        .imem_addr_o       (imem_addr),
        .imem_resp_valid_i (resp_vld),
        .imem_resp_data_i  (resp_data),
        .id_valid_o        (id_valid),
        .id_ready_i        (id_rdy),
        .id_instr_o        (id_instr),
        .id_pc_o           (id_pc),
        .count_o           (count)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    // PC register: reset vector, redirect on flush, advance on trigger.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       tb_pc <= RESET_PC;
        else if (flush)   tb_pc <= FLUSH_PC;
        else if (trigger) tb_pc <= tb_pc + 32'd4;
    end

    // Instruction memory: always ready, in-order, latency mem_lat (1..3), reset with the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_vld <= 3'b000;
        end else begin
            s_vld     <= {s_vld[1:0], trigger};
            s_addr[0] <= imem_addr;
            s_addr[1] <= s_addr[0];
            s_addr[2] <= s_addr[1];
        end
    end
    assign resp_vld  = s_vld[mem_lat - 2'd1];
    assign resp_data = mem_data(s_addr[mem_lat - 2'd1]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after release, just past the edge.
    task automatic do_reset(input logic [1:0] lat, input string tag);
        rst_n   = 1'b0;
        flush   = 1'b0;
        req_rdy = 1'b0;
        id_rdy  = 1'b0;
        mem_lat = lat;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({tag, "_rst_trig"}, 32'(trigger), 32'd0);
        chk({tag, "_rst_idv"},  32'(id_valid), 32'd0);
        chk({tag, "_rst_cnt"},  32'(count), 32'd0);
        chk({tag, "_rst_req"},  32'(req_vld), 32'd0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_pop(input string name, input logic [31:0] exp_pc);
        bit seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            if (id_valid && id_rdy) begin
                seen = 1'b1;
                chk({name, "_pc"}, id_pc, exp_pc);
                chk({name, "_instr"}, id_instr, mem_data(exp_pc));
            end
            step();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=no_pop required=pop", name);
        end
    endtask

    typedef struct {
        logic [2:0]  ctl;   // {flush, req_ready, id_ready}
        logic [2:0]  ex;    // {req_valid, trigger, id_valid}
        logic [2:0]  cnt;
        logic [11:0] addr;  // offsets from RESET_PC
        logic [11:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] c, input logic [2:0] e, input logic [2:0] n,
                                input logic [11:0] a, input logic [11:0] p);
        vec_t v;
        v.ctl = c; v.ex = e; v.cnt = n; v.addr = a; v.pc = p;
        return v;
    endfunction

    vec_t tbl [20];

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming, decode stall until full, drain, then 3 cycles of imem not ready.
        tbl[0]  = mk(3'b011, 3'b110, 3'd0, 12'h000, 12'h000);
        tbl[1]  = mk(3'b011, 3'b110, 3'd1, 12'h004, 12'h000);
        tbl[2]  = mk(3'b011, 3'b111, 3'd2, 12'h008, 12'h000);
        tbl[3]  = mk(3'b011, 3'b111, 3'd2, 12'h00C, 12'h004);
        tbl[4]  = mk(3'b011, 3'b111, 3'd2, 12'h010, 12'h008);
        tbl[5]  = mk(3'b010, 3'b111, 3'd2, 12'h014, 12'h00C);
        tbl[6]  = mk(3'b010, 3'b111, 3'd3, 12'h018, 12'h00C);
        tbl[7]  = mk(3'b010, 3'b001, 3'd4, 12'h01C, 12'h00C);
        tbl[8]  = mk(3'b010, 3'b001, 3'd4, 12'h01C, 12'h00C);
        tbl[9]  = mk(3'b011, 3'b001, 3'd4, 12'h01C, 12'h00C);
        tbl[10] = mk(3'b011, 3'b111, 3'd3, 12'h01C, 12'h010);
        tbl[11] = mk(3'b011, 3'b111, 3'd3, 12'h020, 12'h014);
        tbl[12] = mk(3'b011, 3'b111, 3'd3, 12'h024, 12'h018);
        tbl[13] = mk(3'b011, 3'b111, 3'd3, 12'h028, 12'h01C);
        tbl[14] = mk(3'b001, 3'b101, 3'd3, 12'h02C, 12'h020);
        tbl[15] = mk(3'b001, 3'b101, 3'd2, 12'h02C, 12'h024);
        tbl[16] = mk(3'b001, 3'b101, 3'd1, 12'h02C, 12'h028);
        tbl[17] = mk(3'b011, 3'b110, 3'd0, 12'h02C, 12'h000);
        tbl[18] = mk(3'b011, 3'b110, 3'd1, 12'h030, 12'h000);
        tbl[19] = mk(3'b011, 3'b111, 3'd2, 12'h034, 12'h02C);

        do_reset(2'd1, "vec");
        for (int i = 0; i < 20; i++) begin
            {flush, req_rdy, id_rdy} = tbl[i].ctl;
            @(negedge clk);
            chk($sformatf("v%0d_req", i),  32'(req_vld),  32'(tbl[i].ex[2]));
            chk($sformatf("v%0d_trig", i), 32'(trigger),  32'(tbl[i].ex[1]));
            chk($sformatf("v%0d_idv", i),  32'(id_valid), 32'(tbl[i].ex[0]));
            chk($sformatf("v%0d_cnt", i),  32'(count),    32'(tbl[i].cnt));
            chk($sformatf("v%0d_addr", i), imem_addr, RESET_PC + {20'd0, tbl[i].addr});
            if (tbl[i].ex[0]) begin
                chk($sformatf("v%0d_pc", i), id_pc, RESET_PC + {20'd0, tbl[i].pc});
                chk($sformatf("v%0d_instr", i), id_instr, mem_data(RESET_PC + {20'd0, tbl[i].pc}));
            end
            step();
        end

        // Flush with two fetches in flight and no response that cycle: both are dropped.
        do_reset(2'd3, "t3");
        id_rdy  = 1'b1;
        req_rdy = 1'b1;
        @(negedge clk); chk("t3_trig0", 32'(trigger), 32'd1); step();
        @(negedge clk); chk("t3_trig1", 32'(trigger), 32'd1); step();
        flush = 1'b1;
        @(negedge clk); chk("t3_flush_req", 32'(req_vld), 32'd0); step();
        flush = 1'b0;
        @(negedge clk);
        chk("t3_post_idv", 32'(id_valid), 32'd0);
        chk("t3_post_addr", imem_addr, FLUSH_PC);
        step();
        wait_pop("t3_pop0", FLUSH_PC);
        wait_pop("t3_pop1", FLUSH_PC + 32'd4);

        // Flush coincident with a response, two in flight: exactly one later response dropped.
        do_reset(2'd2, "t4");
        id_rdy  = 1'b1;
        req_rdy = 1'b1;
        @(negedge clk); chk("t4_trig0", 32'(trigger), 32'd1); step();
        @(negedge clk); chk("t4_trig1", 32'(trigger), 32'd1); step();
        flush = 1'b1;
        @(negedge clk); chk("t4_flush_trig", 32'(trigger), 32'd0); step();
        flush = 1'b0;
        @(negedge clk); chk("t4_post_idv", 32'(id_valid), 32'd0); step();
        wait_pop("t4_pop0", FLUSH_PC);
        wait_pop("t4_pop1", FLUSH_PC + 32'd4);

        // Reset asserted mid-burst with three entries allocated.
        do_reset(2'd1, "t6");
        req_rdy = 1'b1;
        repeat (3) step();
        req_rdy = 1'b0;
        @(negedge clk);
        chk("t6_pre_cnt", 32'(count), 32'd3);
        chk("t6_pre_idv", 32'(id_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_idv", 32'(id_valid), 32'd0);
        chk("t6_rst_cnt", 32'(count), 32'd0);
        chk("t6_rst_trig", 32'(trigger), 32'd0);
        step();
        rst_n   = 1'b1;
        req_rdy = 1'b1;
        id_rdy  = 1'b1;
        @(negedge clk);
        chk("t6_rel_req", 32'(req_vld), 32'd1);
        chk("t6_rel_addr", imem_addr, RESET_PC);
        step();
        wait_pop("t6_pop0", RESET_PC);
        wait_pop("t6_pop1", RESET_PC + 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
